// File: rtl/multiplier_mac_pipe_pkg.sv
// Shared defaults, result mode type and saturation limit helpers for the MAC pipe.
package multiplier_mac_pipe_pkg;

  localparam int unsigned DefBitwidth = 8;
  localparam int unsigned DefAccwidth = 24;
  localparam int unsigned DefStages   = 2;

  // Per-sample mode carried down the pipe alongside the product.
  typedef enum logic {
    ModeLoad = 1'b0,
    ModeAcc  = 1'b1
  } acc_mode_e;

  // Largest representable accumulator value (caller truncates to accw bits).
  function automatic logic [63:0] sat_hi(input int unsigned accw, input int unsigned sgn);
    return (sgn != 0) ? (64'd1 << (accw - 1)) - 64'd1 : (64'd1 << accw) - 64'd1;
  endfunction

  // Smallest representable accumulator value, two's complement in 64 bits.
  function automatic logic [63:0] sat_lo(input int unsigned accw, input int unsigned sgn);
    return (sgn != 0) ? ~((64'd1 << (accw - 1)) - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/multiplier_mac_pipe_if.sv
// Operand/result bundle of the MAC pipe; master drives operands, slave returns results.
interface multiplier_mac_pipe_if
  import multiplier_mac_pipe_pkg::*;
#(
  parameter int unsigned BITWIDTH = DefBitwidth,
  parameter int unsigned ACCWIDTH = DefAccwidth
);
  logic                iEn;
  logic                iClr;
  logic                iAcc;
  logic [BITWIDTH-1:0] iData0;
  logic [BITWIDTH-1:0] iData1;
  logic                oValid;
  logic [ACCWIDTH-1:0] oData;
  logic                oOvf;

  modport master (
    output iEn, iClr, iAcc, iData0, iData1,
    input  oValid, oData, oOvf
  );

  modport slave (
    input  iEn, iClr, iAcc, iData0, iData1,
    output oValid, oData, oOvf
  );
endinterface

// File: rtl/multiplier_pipe.sv
// Operand capture plus a STAGES-deep product register chain; valid and mode ride along.
module multiplier_pipe
  import multiplier_mac_pipe_pkg::*;
#(
  parameter int unsigned BITWIDTH = DefBitwidth,
  parameter int unsigned STAGES   = DefStages,
  parameter int unsigned SIGNED   = 0
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iEn,
  input  logic                    iClr,
  input  logic                    iAcc,
  input  logic [BITWIDTH-1:0]     iData0,
  input  logic [BITWIDTH-1:0]     iData1,
  output logic [2*BITWIDTH-1:0]   oProd,
  output logic                    oValid,
  output acc_mode_e               oMode
);
  localparam int unsigned PW = 2 * BITWIDTH;

  logic [BITWIDTH-1:0] r_a;
  logic [BITWIDTH-1:0] r_b;
  logic                r_cap_vld;
  acc_mode_e           r_cap_mode;
  logic [PW-1:0]       r_prod  [STAGES];
  logic [STAGES-1:0]   r_pvld;
  acc_mode_e           r_pmode [STAGES];
  logic [PW-1:0]       w_prod;

  // Low PW bits of the product; signed mode only needs sign-extended operands.
  if (SIGNED != 0) begin : g_signed
    assign w_prod = {{BITWIDTH{r_a[BITWIDTH-1]}}, r_a} * {{BITWIDTH{r_b[BITWIDTH-1]}}, r_b};
  end else begin : g_unsigned
    assign w_prod = {{BITWIDTH{1'b0}}, r_a} * {{BITWIDTH{1'b0}}, r_b};
  end

  // Capture operands and shift the product chain; clear kills every valid bit in flight.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_a        <= '0;
      r_b        <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_mode <= ModeLoad;
      r_pvld     <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_prod[i]  <= '0;
        r_pmode[i] <= ModeLoad;
      end
    end else if (iClr) begin
      r_cap_vld <= 1'b0;
      r_pvld    <= '0;
    end else begin
      r_cap_vld  <= iEn;
      r_cap_mode <= acc_mode_e'(iAcc);
      if (iEn) begin
        r_a <= iData0;
        r_b <= iData1;
      end
      r_prod[0]  <= w_prod;
      r_pvld[0]  <= r_cap_vld;
      r_pmode[0] <= r_cap_mode;
      for (int i = 1; i < STAGES; i++) begin
        r_prod[i]  <= r_prod[i-1];
        r_pvld[i]  <= r_pvld[i-1];
        r_pmode[i] <= r_pmode[i-1];
      end
    end
  end

  assign oProd  = r_prod[STAGES-1];
  assign oValid = r_pvld[STAGES-1];
  assign oMode  = r_pmode[STAGES-1];

endmodule

// File: rtl/multiplier_mac_pipe.sv
// Pipelined multiply-accumulate: product pipe followed by a saturating load/accumulate stage.
// Interface parameters must match BITWIDTH/ACCWIDTH here; ACCWIDTH >= 2*BITWIDTH, STAGES >= 1.
module multiplier_mac_pipe
  import multiplier_mac_pipe_pkg::*;
#(
  parameter int unsigned BITWIDTH = DefBitwidth,
  parameter int unsigned ACCWIDTH = DefAccwidth,
  parameter int unsigned STAGES   = DefStages,
  parameter int unsigned SIGNED   = 0
) (
  input logic                  iClk,
  input logic                  iRstN,
  multiplier_mac_pipe_if.slave bus
);
  localparam int unsigned PW   = 2 * BITWIDTH;
  localparam int unsigned ExtW = ACCWIDTH + 1 - PW;
  localparam logic [ACCWIDTH-1:0] SatHi = ACCWIDTH'(sat_hi(ACCWIDTH, SIGNED));
  localparam logic [ACCWIDTH-1:0] SatLo = ACCWIDTH'(sat_lo(ACCWIDTH, SIGNED));

  logic [PW-1:0]       w_prod;
  logic                w_pvld;
  acc_mode_e           w_mode;
  logic [ACCWIDTH:0]   w_ext;
  logic [ACCWIDTH:0]   w_acc_ext;
  logic [ACCWIDTH:0]   w_sum;
  logic                w_over;
  logic [ACCWIDTH-1:0] w_data_d;
  logic                w_ovf_d;
  logic                w_valid_d;
  logic [ACCWIDTH-1:0] r_data;
  logic                r_ovf;
  logic                r_valid;

  multiplier_pipe #(
    .BITWIDTH (BITWIDTH),
    .STAGES   (STAGES),
    .SIGNED   (SIGNED)
  ) u_pipe (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iEn    (bus.iEn),
    .iClr   (bus.iClr),
    .iAcc   (bus.iAcc),
    .iData0 (bus.iData0),
    .iData1 (bus.iData1),
    .oProd  (w_prod),
    .oValid (w_pvld),
    .oMode  (w_mode)
  );

  // Widen product and accumulator by one bit so the sum cannot wrap before the range check.
  always_comb begin
    w_ext     = (SIGNED != 0) ? {{ExtW{w_prod[PW-1]}}, w_prod} : {{ExtW{1'b0}}, w_prod};
    w_acc_ext = (SIGNED != 0) ? {r_data[ACCWIDTH-1], r_data} : {1'b0, r_data};
    w_sum     = w_acc_ext + w_ext;
    // Signed overflow shows as disagreement between the two top bits.
    w_over    = (SIGNED != 0) ? (w_sum[ACCWIDTH] ^ w_sum[ACCWIDTH-1]) : w_sum[ACCWIDTH];
  end

  // Next output state: bubbles hold, loads replace, accumulates add with clamping.
  always_comb begin
    w_data_d  = r_data;
    w_ovf_d   = r_ovf;
    w_valid_d = 1'b0;
    if (w_pvld) begin
      w_valid_d = 1'b1;
      if (w_mode == ModeLoad) begin
        w_data_d = w_ext[ACCWIDTH-1:0];
      end else if (w_over) begin
        w_ovf_d  = 1'b1;
        w_data_d = ((SIGNED != 0) && w_sum[ACCWIDTH]) ? SatLo : SatHi;
      end else begin
        w_data_d = w_sum[ACCWIDTH-1:0];
      end
    end
  end

  // Output registers; clear wins over any sample completing this edge.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else if (bus.iClr) begin
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_data_d;
      r_ovf   <= w_ovf_d;
      r_valid <= w_valid_d;
    end
  end

  assign bus.oData  = r_data;
  assign bus.oOvf   = r_ovf;
  assign bus.oValid = r_valid;

endmodule

// File: tb/tb_multiplier_mac_pipe.sv
// Scoreboard bench: unsigned and signed MAC instances share stimulus; a reference model
// computes each sample's expected result at issue time, a negedge monitor checks outputs.
module tb_multiplier_mac_pipe;
  localparam int unsigned BW  = 8;
  localparam int unsigned AW  = 20;
  localparam int unsigned LAT = 3;  // STAGES + 1 edges from issue to oValid

  typedef struct {
    int          due;
    logic [19:0] data;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;

  exp_t        q_u[$];
  exp_t        q_s[$];
  longint      m_acc_u = 0, m_acc_s = 0;
  bit          m_ovf_u = 0, m_ovf_s = 0;
  logic [19:0] hold_u = '0, hold_s = '0;
  logic        hold_ovf_u = 1'b0, hold_ovf_s = 1'b0;

  multiplier_mac_pipe_if #(.BITWIDTH(BW), .ACCWIDTH(AW)) bus_u ();
  multiplier_mac_pipe_if #(.BITWIDTH(BW), .ACCWIDTH(AW)) bus_s ();

  multiplier_mac_pipe #(.BITWIDTH(BW), .ACCWIDTH(AW), .STAGES(2), .SIGNED(0)) dut_u (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus_u)
  );

  multiplier_mac_pipe #(.BITWIDTH(BW), .ACCWIDTH(AW), .STAGES(2), .SIGNED(1)) dut_s (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Reference: exact arithmetic on integers, clamp to the accumulator range.
  task automatic model_issue(input bit sgn, input bit acc, input logic [7:0] a,
                             input logic [7:0] b);
    longint p, s, hi, lo, cur;
    int     sa, sb;
    bit     ov;
    exp_t   e;
    cur = sgn ? m_acc_s : m_acc_u;
    ov  = sgn ? m_ovf_s : m_ovf_u;
    sa  = $signed(a);
    sb  = $signed(b);
    p   = sgn ? longint'(sa) * longint'(sb) : longint'(a) * longint'(b);
    hi  = sgn ? (longint'(1) << (AW - 1)) - 1 : (longint'(1) << AW) - 1;
    lo  = sgn ? -(longint'(1) << (AW - 1)) : 0;
    if (!acc) s = p;
    else begin
      s = cur + p;
      if (s > hi) begin s = hi; ov = 1'b1; end
      else if (s < lo) begin s = lo; ov = 1'b1; end
    end
    e.due  = edge_cnt + LAT;
    e.data = s[19:0];
    e.ovf  = ov;
    if (sgn) begin m_acc_s = s; m_ovf_s = ov; q_s.push_back(e); end
    else     begin m_acc_u = s; m_ovf_u = ov; q_u.push_back(e); end
  endtask

  // Drive one cycle of stimulus to both instances, then update the model for that edge.
  task automatic step(input bit en, input bit clr, input bit acc, input logic [7:0] a,
                      input logic [7:0] b);
    bus_u.iEn = en;  bus_u.iClr = clr;  bus_u.iAcc = acc;  bus_u.iData0 = a;  bus_u.iData1 = b;
    bus_s.iEn = en;  bus_s.iClr = clr;  bus_s.iAcc = acc;  bus_s.iData0 = a;  bus_s.iData1 = b;
    @(posedge clk);
    #1;
    if (!rst_n) return;
    if (clr) begin
      q_u.delete();  q_s.delete();
      m_acc_u = 0;   m_acc_s = 0;
      m_ovf_u = 0;   m_ovf_s = 0;
      hold_u = '0;   hold_s = '0;
      hold_ovf_u = 1'b0;  hold_ovf_s = 1'b0;
    end else if (en) begin
      model_issue(1'b0, acc, a, b);
      model_issue(1'b1, acc, a, b);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic mon(input bit sgn, input logic v, input logic [19:0] d, input logic o);
    exp_t  e;
    string nm;
    nm = sgn ? "s" : "u";
    if (v === 1'b1) begin
      if ((sgn ? q_s.size() : q_u.size()) == 0) begin
        total++;
        bad++;
        $display("FAIL %s_stray_valid: got oValid=1 oData=%0h want no output (edge %0d)",
                 nm, d, edge_cnt);
      end else begin
        if (sgn) e = q_s.pop_front();
        else     e = q_u.pop_front();
        chk({nm, "_latency"}, edge_cnt, e.due);
        chk({nm, "_data"}, {12'h0, d}, {12'h0, e.data});
        chk({nm, "_ovf"}, {31'h0, o}, {31'h0, e.ovf});
        if (sgn) begin hold_s = e.data; hold_ovf_s = e.ovf; end
        else     begin hold_u = e.data; hold_ovf_u = e.ovf; end
      end
    end else begin
      chk({nm, "_valid"}, {31'h0, v}, 32'h0);
      chk({nm, "_hold_data"}, {12'h0, d}, {12'h0, sgn ? hold_s : hold_u});
      chk({nm, "_hold_ovf"}, {31'h0, o}, {31'h0, sgn ? hold_ovf_s : hold_ovf_u});
    end
  endtask

  // Monitor: compare outputs away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("u_rst_valid", {31'h0, bus_u.oValid}, 32'h0);
      chk("u_rst_data", {12'h0, bus_u.oData}, 32'h0);
      chk("u_rst_ovf", {31'h0, bus_u.oOvf}, 32'h0);
      chk("s_rst_valid", {31'h0, bus_s.oValid}, 32'h0);
      chk("s_rst_data", {12'h0, bus_s.oData}, 32'h0);
      chk("s_rst_ovf", {31'h0, bus_s.oOvf}, 32'h0);
    end else begin
      mon(1'b0, bus_u.oValid, bus_u.oData, bus_u.oOvf);
      mon(1'b1, bus_s.oValid, bus_s.oData, bus_s.oOvf);
    end
  end

  initial begin
    logic [7:0] a, b;
    rst_n = 1'b0;
    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, i[0], 8'(i * 37 + 5), 8'(i * 11 + 3));
    step(1'b1, 1'b0, 1'b0, 8'd200, 8'd250);
    // Deassert between edges with a sample already presented.
    #2 rst_n = 1'b1;
    // Plain product, then hold.
    step(1'b1, 1'b0, 1'b0, 8'd200, 8'd250);
    idle(5);
    // Accumulate streaming then a bubble.
    step(1'b1, 1'b0, 1'b0, 8'd255, 8'd255);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'd255, 8'd255);
    idle(5);
    // Saturation from zero, then a load that must not clear the sticky flag.
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b1, 8'd255, 8'd255);
    step(1'b1, 1'b0, 1'b0, 8'd1, 8'd1);
    idle(5);
    // Signed corners and the negative limit.
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'h80, 8'h7f);
    step(1'b1, 1'b0, 1'b1, 8'h80, 8'h80);
    for (int i = 0; i < 34; i++) step(1'b1, 1'b0, 1'b1, 8'h80, 8'h7f);
    idle(5);
    // Clear mid-flight: both samples dropped, next one proceeds normally.
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 8'd3, 8'd4);
    step(1'b1, 1'b1, 1'b0, 8'd5, 8'd6);
    step(1'b1, 1'b0, 1'b0, 8'd7, 8'd8);
    idle(5);
    // Randomized traffic with biased corner operands.
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? 8'hff : 8'h80;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) != 0) ? 8'hff : 8'h80;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
           a, b);
    end
    idle(6);
    @(negedge clk);
    #1;
    chk("u_drain", q_u.size(), 32'h0);
    chk("s_drain", q_s.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplier_mac_pipe.md
Name: multiplier_mac_pipe

Overview:
Parametrised, pipelined multiply-accumulate unit: the next generation of the registered multiplier.
- Accepts one operand pair per cycle.
- Multiplies through a configurable-depth pipeline, signed or unsigned.
- Either outputs the plain product or accumulates it into a saturating accumulator.
- Sits in datapaths that need dot-product / running-sum reduction with a valid-qualified output.

Parameters:
BITWIDTH, 8, operand width in bits
ACCWIDTH, 24, accumulator/output width; must be >= 2*BITWIDTH
STAGES, 2, product pipeline depth (>=1)
SIGNED, 0, 1 = two's-complement operands, product and accumulator; 0 = unsigned

Ports:
iClk  input  1  clock; all state updates on rising edge
iRstN  input  1  asynchronous active-low reset
iEn  input  1  input valid; operands sampled this edge when high
iClr  input  1  synchronous clear: flush pipeline, zero accumulator and flags
iAcc  input  1  mode per sample: 1 = accumulate, 0 = load plain product
iData0  input  BITWIDTH  operand A
iData1  input  BITWIDTH  operand B
oValid  output  1  oData updated by a valid sample this cycle (one-cycle pulse per sample)
oData  output  ACCWIDTH  accumulator / product result
oOvf  output  1  sticky saturation flag

Behaviour:
- Reset (iRstN low, async): every pipeline register, every valid bit, oData, oValid and oOvf are 0. Operations in flight are lost.
- No back-pressure: the pipeline advances every cycle. The valid bit and iAcc travel with each sample. Bubbles (iEn=0) never touch the accumulator.
- Latency:
  - A sample taken at edge k writes the product register at edge k+STAGES.
  - It updates oData and pulses oValid at edge k+STAGES+1.
  - Throughput is 1 sample/cycle.
- Product:
  - Full 2*BITWIDTH width.
  - Sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACCWIDTH+1 before use.
- Output stage, when a valid sample arrives:
  - iAcc=0: oData <= extended product.
  - iAcc=1: sum = oData + extended product, computed at ACCWIDTH+1 bits.
    - If the sum exceeds the ACCWIDTH range, clamp: unsigned to 2^ACCWIDTH-1; signed to +2^(ACCWIDTH-1)-1 or -2^(ACCWIDTH-1).
    - On clamp, set oOvf.
    - Otherwise oData <= sum.
- oOvf is sticky. Only iClr or reset clears it. A load (iAcc=0) does not clear it.
- When no valid sample arrives: oData holds and oValid=0.
- iClr (synchronous, highest priority after reset):
  - Next edge zeroes all valid bits, oData, oValid and oOvf.
  - An iEn asserted in the same cycle is discarded.
  - Samples already in flight are dropped and produce no oValid.
- Samples issued the cycle after iClr deasserts proceed normally.
- Back-to-back accumulate samples chain with no hazard: each sees the previous result.

Decomposition:
- Shared defines file (same scheme as existing multiplier defines): default BITWIDTH, ACCWIDTH and STAGES values, plus saturation limit constants derived from ACCWIDTH and SIGNED.
- One sub-module: multiplier_pipe.
  - Contents: operand capture, STAGES-deep product register chain with valid and mode shift, clear/flush.
  - Output: product, valid and mode to the accumulator stage in multiplier_mac_pipe.

Test Plan:
All scenarios use BITWIDTH=8, ACCWIDTH=20, STAGES=2 unless stated.
1. Reset: hold iRstN low, toggle inputs -> oData=0, oValid=0, oOvf=0. Async deassert mid-stream: no stray oValid.
2. Plain product: iEn=1, iAcc=0, 200*250 at edge 0 -> oValid exactly at edge 3, oData=50000. oData holds 50000 afterwards with oValid=0.
3. Accumulate streaming: first sample iAcc=0, next three iAcc=1, all 255*255, back-to-back -> oData 65025, 130050, 195075, 260100 on 4 consecutive oValid cycles. Then one bubble cycle -> no change.
4. Saturation: 17 accumulate samples of 255*255 from zero -> 17th result clamps to 1048575, oOvf=1. A following iAcc=0 load of 1*1 -> oData=1, oOvf stays 1.
5. Signed mode (SIGNED=1):
   - Load -128*127 -> oData=-16256.
   - Accumulate -128*-128 -> oData=128.
   - Drive toward the negative limit -> clamp at -524288, oOvf=1.
6. Clear mid-flight: iEn at edge 0 and edge 1, iClr at edge 1 -> no oValid ever appears, oData=0, oOvf=0. A new sample issued at edge 2 produces its result at edge 5.
